// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the 5-stage RISC-V core pipeline.
//   CTRL_W            width of the packed control word carried down the pipe
//   CTRL_*            bit positions inside the packed control word
//   alu_op_e          2-bit ALU operation class decoded in ID
//   BUBBLE_CTRL       control word of a bubble (no side effects)
//   make_ctrl()       packs individual control fields into a control word
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int unsigned CTRL_W = 9;

    // Control word layout, MSB first:
    // reg_write, mem_read, mem_write, mem_2_reg, alu_src, branch, jump, alu_op[1:0]
    localparam int unsigned CTRL_REG_WRITE  = 8;
    localparam int unsigned CTRL_MEM_READ   = 7;
    localparam int unsigned CTRL_MEM_WRITE  = 6;
    localparam int unsigned CTRL_MEM_2_REG  = 5;
    localparam int unsigned CTRL_ALU_SRC    = 4;
    localparam int unsigned CTRL_BRANCH     = 3;
    localparam int unsigned CTRL_JUMP       = 2;
    localparam int unsigned CTRL_ALU_OP_MSB = 1;
    localparam int unsigned CTRL_ALU_OP_LSB = 0;

    typedef enum logic [1:0] {
        ALU_OP_ADD    = 2'b00,  // address generation for loads/stores
        ALU_OP_BRANCH = 2'b01,  // compare for conditional branches
        ALU_OP_FUNCT  = 2'b10,  // R-type, operation from funct3/funct7
        ALU_OP_IMM    = 2'b11   // I-type, operation from funct3
    } alu_op_e;

    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

    function automatic logic [CTRL_W-1:0] make_ctrl(
        input logic    reg_write,
        input logic    mem_read,
        input logic    mem_write,
        input logic    mem_2_reg,
        input logic    alu_src,
        input logic    branch,
        input logic    jump,
        input alu_op_e alu_op
    );
        logic [CTRL_W-1:0] c;
        c = BUBBLE_CTRL;
        c[CTRL_REG_WRITE] = reg_write;
        c[CTRL_MEM_READ]  = mem_read;
        c[CTRL_MEM_WRITE] = mem_write;
        c[CTRL_MEM_2_REG] = mem_2_reg;
        c[CTRL_ALU_SRC]   = alu_src;
        c[CTRL_BRANCH]    = branch;
        c[CTRL_JUMP]      = jump;
        c[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB] = alu_op;
        return c;
    endfunction

endpackage

// File: rtl/load_use_hazard_unit.sv
// ---------------------------------------------------------------------------
// load_use_hazard_unit
// Combinational load-use hazard detection between the load sitting in EX
// and the instruction currently in ID.
//   ex_mem_read   instruction in EX is a load
//   ex_rd         destination of the instruction in EX
//   id_rs1/rs2    source indices of the instruction in ID
//   id_use_rs1/2  instruction in ID actually reads that source
//   flush         instruction in ID is being squashed
//   hazard        load result is needed by ID next cycle
//   stall         hold PC and IF/ID (hazard unless squashed)
// ---------------------------------------------------------------------------
module load_use_hazard_unit #(
    parameter int unsigned REG_A_W = 5
) (
    input  logic               ex_mem_read,
    input  logic [REG_A_W-1:0] ex_rd,
    input  logic [REG_A_W-1:0] id_rs1,
    input  logic [REG_A_W-1:0] id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic               flush,
    output logic               hazard,
    output logic               stall
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        // Only compare sources the instruction really reads, so immediate
        // fields that alias a register index never cause a false stall.
        rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
        // x0 is never written, so a load to x0 carries no dependency.
        hazard    = ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);
        stall     = hazard && !flush;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use stall detection.
//   clk, arst            clock (rising edge), async active-high reset
//   en                   global pipeline enable, 0 freezes everything
//   flush                squash the instruction in ID (bubble into EX)
//   *__IF_ID             decoded operands/indices/control from ID
//   *__ID_EX             registered copies presented to EX / forwarding
//   stall                hold PC and IF/ID this cycle
//   stall_cnt            saturating count of load-use stalls taken
// A bubble zeroes every register, indices included, so the forwarding
// unit sees no match and nothing is written back.
// ---------------------------------------------------------------------------
module id_ex_stage
    import core_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned REG_A_W = 5,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               en,
    input  logic               flush,
    input  logic [REG_A_W-1:0] RS1__IF_ID,
    input  logic [REG_A_W-1:0] RS2__IF_ID,
    input  logic [REG_A_W-1:0] RD__IF_ID,
    input  logic               USE_RS1__IF_ID,
    input  logic               USE_RS2__IF_ID,
    input  logic [CTRL_W-1:0]  CTRL__IF_ID,
    input  logic [DATA_W-1:0]  RS1_DATA__IF_ID,
    input  logic [DATA_W-1:0]  RS2_DATA__IF_ID,
    input  logic [DATA_W-1:0]  IMM__IF_ID,
    input  logic [DATA_W-1:0]  PC__IF_ID,
    output logic [REG_A_W-1:0] RS1__ID_EX,
    output logic [REG_A_W-1:0] RS2__ID_EX,
    output logic [REG_A_W-1:0] RD__ID_EX,
    output logic [CTRL_W-1:0]  CTRL__ID_EX,
    output logic [DATA_W-1:0]  RS1_DATA__ID_EX,
    output logic [DATA_W-1:0]  RS2_DATA__ID_EX,
    output logic [DATA_W-1:0]  IMM__ID_EX,
    output logic [DATA_W-1:0]  PC__ID_EX,
    output logic               stall,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic hazard;
    logic bubble;

    load_use_hazard_unit #(
        .REG_A_W (REG_A_W)
    ) u_hazard (
        .ex_mem_read (CTRL__ID_EX[CTRL_MEM_READ]),
        .ex_rd       (RD__ID_EX),
        .id_rs1      (RS1__IF_ID),
        .id_rs2      (RS2__IF_ID),
        .id_use_rs1  (USE_RS1__IF_ID),
        .id_use_rs2  (USE_RS2__IF_ID),
        .flush       (flush),
        .hazard      (hazard),
        .stall       (stall)
    );

    // Flush outranks the hazard, but both produce the same bubble.
    assign bubble = flush || hazard;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            RS1__ID_EX      <= '0;
            RS2__ID_EX      <= '0;
            RD__ID_EX       <= '0;
            CTRL__ID_EX     <= BUBBLE_CTRL;
            RS1_DATA__ID_EX <= '0;
            RS2_DATA__ID_EX <= '0;
            IMM__ID_EX      <= '0;
            PC__ID_EX       <= '0;
        end else if (en) begin
            if (bubble) begin
                RS1__ID_EX      <= '0;
                RS2__ID_EX      <= '0;
                RD__ID_EX       <= '0;
                CTRL__ID_EX     <= BUBBLE_CTRL;
                RS1_DATA__ID_EX <= '0;
                RS2_DATA__ID_EX <= '0;
                IMM__ID_EX      <= '0;
                PC__ID_EX       <= '0;
            end else begin
                RS1__ID_EX      <= RS1__IF_ID;
                RS2__ID_EX      <= RS2__IF_ID;
                RD__ID_EX       <= RD__IF_ID;
                CTRL__ID_EX     <= CTRL__IF_ID;
                RS1_DATA__ID_EX <= RS1_DATA__IF_ID;
                RS2_DATA__ID_EX <= RS2_DATA__IF_ID;
                IMM__ID_EX      <= IMM__IF_ID;
                PC__ID_EX       <= PC__IF_ID;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt <= '0;
        end else if (en && stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    import core_pkg::*;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned REG_A_W = 5;
    localparam int unsigned CNT_W   = 2;

    logic               clk;
    logic               arst;
    logic               en;
    logic               flush;
    logic [REG_A_W-1:0] rs1_i, rs2_i, rd_i;
    logic               use1_i, use2_i;
    logic [CTRL_W-1:0]  ctrl_i;
    logic [DATA_W-1:0]  d1_i, d2_i, imm_i, pc_i;
    logic [REG_A_W-1:0] rs1_o, rs2_o, rd_o;
    logic [CTRL_W-1:0]  ctrl_o;
    logic [DATA_W-1:0]  d1_o, d2_o, imm_o, pc_o;
    logic               stall;
    logic [CNT_W-1:0]   stall_cnt;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(
        .DATA_W  (DATA_W),
        .REG_A_W (REG_A_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk             (clk),
        .arst            (arst),
        .en              (en),
        .flush           (flush),
        .RS1__IF_ID      (rs1_i),
        .RS2__IF_ID      (rs2_i),
        .RD__IF_ID       (rd_i),
        .USE_RS1__IF_ID  (use1_i),
        .USE_RS2__IF_ID  (use2_i),
        .CTRL__IF_ID     (ctrl_i),
        .RS1_DATA__IF_ID (d1_i),
        .RS2_DATA__IF_ID (d2_i),
        .IMM__IF_ID      (imm_i),
        .PC__IF_ID       (pc_i),
        .RS1__ID_EX      (rs1_o),
        .RS2__ID_EX      (rs2_o),
        .RD__ID_EX       (rd_o),
        .CTRL__ID_EX     (ctrl_o),
        .RS1_DATA__ID_EX (d1_o),
        .RS2_DATA__ID_EX (d2_o),
        .IMM__ID_EX      (imm_o),
        .PC__ID_EX       (pc_o),
        .stall           (stall),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1;
        #1;
        arst = 1'b0;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic [CTRL_W-1:0] c,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] imm, input logic [63:0] pc);
        rs1_i = rs1; rs2_i = rs2; rd_i = rd; use1_i = u1; use2_i = u2; ctrl_i = c;
        d1_i = a; d2_i = b; imm_i = imm; pc_i = pc;
    endtask

    typedef struct {
        logic [4:0] ld_rd;
        logic       ld_mem_read;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       fl;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[9];

    logic [CTRL_W-1:0] ld_ctrl, add_ctrl, addi_ctrl;
    logic [CNT_W-1:0]  sat_exp[5];

    initial begin
        ld_ctrl   = make_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ALU_OP_ADD);
        add_ctrl  = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_OP_FUNCT);
        addi_ctrl = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_OP_IMM);

        //          ld_rd mr  rs1    rs2    u1 u2 fl exp
        vecs[0] = '{5'd5,  1, 5'd5,  5'd7,  1, 1, 0, 1}; // add x6,x5,x7
        vecs[1] = '{5'd5,  1, 5'd3,  5'd5,  1, 0, 0, 0}; // addi, imm field aliases x5
        vecs[2] = '{5'd0,  1, 5'd0,  5'd0,  1, 1, 0, 0}; // lw x0
        vecs[3] = '{5'd5,  1, 5'd9,  5'd5,  1, 1, 0, 1}; // rs2 dependency
        vecs[4] = '{5'd5,  0, 5'd5,  5'd5,  1, 1, 0, 0}; // producer is not a load
        vecs[5] = '{5'd5,  1, 5'd5,  5'd7,  1, 1, 1, 0}; // flushed consumer
        vecs[6] = '{5'd31, 1, 5'd31, 5'd31, 1, 1, 0, 1}; // top register index
        vecs[7] = '{5'd5,  1, 5'd5,  5'd5,  0, 0, 0, 0}; // no source used
        vecs[8] = '{5'd5,  1, 5'd4,  5'd6,  1, 1, 0, 0}; // back-to-back load, independent

        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

        arst = 1'b1; en = 1'b1; flush = 1'b0;
        drive(0, 0, 0, 0, 0, '0, 0, 0, 0, 0);
        #12;
        arst = 1'b0;
        #1;
        check("reset_ctrl", 64'(ctrl_o), 0);
        check("reset_rd", 64'(rd_o), 0);
        check("reset_pc", pc_o, 0);
        check("reset_stall", 64'(stall), 0);
        check("reset_cnt", 64'(stall_cnt), 0);

        // Table: load into ID/EX, then present a consumer in ID.
        for (int i = 0; i < 9; i++) begin
            do_reset();
            drive(5'd2, 5'd0, vecs[i].ld_rd, 1, 0,
                  vecs[i].ld_mem_read ? ld_ctrl : add_ctrl, 64'h10, 0, 64'h8, 64'h200);
            tick();
            drive(vecs[i].rs1, vecs[i].rs2, 5'd6, vecs[i].u1, vecs[i].u2, add_ctrl,
                  64'h1, 64'h2, 0, 64'h204);
            flush = vecs[i].fl;
            #1;
            check($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].exp_stall));
            tick();
            // The cycle after a hazard, flush or not, ID/EX must be a bubble.
            if (vecs[i].exp_stall || vecs[i].fl)
                check($sformatf("vec%0d_bubble_rd", i), 64'(rd_o), 0);
            else
                check($sformatf("vec%0d_capture_rd", i), 64'(rd_o), 6);
            flush = 1'b0;
        end

        // Load-use: stall, bubble, then capture of the stalled instruction.
        do_reset();
        drive(5'd2, 5'd0, 5'd5, 1, 0, ld_ctrl, 64'h1000, 0, 64'h8, 64'h100);
        tick();
        check("lu_ld_rd", 64'(rd_o), 5);
        check("lu_ld_ctrl", 64'(ctrl_o), 64'(ld_ctrl));
        check("lu_ld_imm", imm_o, 64'h8);
        drive(5'd5, 5'd7, 5'd6, 1, 1, add_ctrl, 64'hAAAA, 64'hBBBB, 0, 64'h104);
        #1;
        check("lu_stall", 64'(stall), 1);
        tick();
        check("lu_bubble_ctrl", 64'(ctrl_o), 0);
        check("lu_bubble_rd", 64'(rd_o), 0);
        check("lu_bubble_rs1", 64'(rs1_o), 0);
        check("lu_bubble_pc", pc_o, 0);
        check("lu_stall_clear", 64'(stall), 0);
        check("lu_cnt1", 64'(stall_cnt), 1);
        tick();
        check("lu_add_rd", 64'(rd_o), 6);
        check("lu_add_rs1", 64'(rs1_o), 5);
        check("lu_add_rs2", 64'(rs2_o), 7);
        check("lu_add_ctrl", 64'(ctrl_o), 64'(add_ctrl));
        check("lu_add_d1", d1_o, 64'hAAAA);
        check("lu_add_d2", d2_o, 64'hBBBB);
        check("lu_add_pc", pc_o, 64'h104);
        check("lu_cnt_hold", 64'(stall_cnt), 1);

        // Async reset mid-stall, between edges.
        drive(5'd2, 5'd0, 5'd5, 1, 0, ld_ctrl, 64'h1, 0, 64'h4, 64'h300);
        tick();
        drive(5'd5, 5'd0, 5'd8, 1, 0, addi_ctrl, 0, 0, 64'h5, 64'h304);
        #1;
        check("rst_pre_stall", 64'(stall), 1);
        arst = 1'b1;
        #1;
        check("rst_mid_ctrl", 64'(ctrl_o), 0);
        check("rst_mid_rd", 64'(rd_o), 0);
        check("rst_mid_imm", imm_o, 0);
        check("rst_mid_pc", pc_o, 0);
        check("rst_mid_stall", 64'(stall), 0);
        check("rst_mid_cnt", 64'(stall_cnt), 0);
        arst = 1'b0;

        // Flush beats hazard.
        do_reset();
        drive(5'd2, 5'd0, 5'd5, 1, 0, ld_ctrl, 64'h1, 0, 64'h4, 64'h400);
        tick();
        drive(5'd5, 5'd7, 5'd6, 1, 1, add_ctrl, 64'h11, 64'h22, 0, 64'h404);
        flush = 1'b1;
        #1;
        check("fl_stall", 64'(stall), 0);
        tick();
        flush = 1'b0;
        check("fl_ctrl", 64'(ctrl_o), 0);
        check("fl_rd", 64'(rd_o), 0);
        check("fl_cnt", 64'(stall_cnt), 0);

        // Freeze with hazard present.
        do_reset();
        drive(5'd2, 5'd0, 5'd5, 1, 0, ld_ctrl, 64'h77, 0, 64'h4, 64'h500);
        tick();
        drive(5'd5, 5'd7, 5'd6, 1, 1, add_ctrl, 64'h11, 64'h22, 0, 64'h504);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("frz%0d_stall", k), 64'(stall), 1);
            check($sformatf("frz%0d_rd", k), 64'(rd_o), 5);
            check($sformatf("frz%0d_ctrl", k), 64'(ctrl_o), 64'(ld_ctrl));
            check($sformatf("frz%0d_d1", k), d1_o, 64'h77);
            check($sformatf("frz%0d_pc", k), pc_o, 64'h500);
            check($sformatf("frz%0d_cnt", k), 64'(stall_cnt), 0);
        end
        en = 1'b1;

        // Saturation of the 2-bit counter.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(5'd2, 5'd0, 5'd5, 1, 0, ld_ctrl, 0, 0, 64'h4, 64'h600);
            tick();
            drive(5'd5, 5'd7, 5'd6, 1, 1, add_ctrl, 0, 0, 0, 64'h604);
            #1;
            check($sformatf("sat%0d_stall", k), 64'(stall), 1);
            tick();
            check($sformatf("sat%0d_cnt", k), 64'(stall_cnt), 64'(sat_exp[k]));
            tick();
            check($sformatf("sat%0d_rd", k), 64'(rd_o), 6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
